// File: rtl/avmm_step_gen.sv
// avmm_step_gen: Avalon-MM slave that turns queued move commands into timed step/dir pulses.
// Define STEP_GEN_IRQ_EN to add the irq output and the STATUS bit4 clear.
module avmm_step_gen #(
  parameter int CNT_W      = 16,
  parameter int PULSE_CYC  = 50,
  parameter int DIR_SETUP  = 25,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [1:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic        avs_waitrequest,
  output logic        step,
`ifdef STEP_GEN_IRQ_EN
  output logic        dir,
  output logic        irq
`else
  output logic        dir
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0]   LVL_FULL   = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] PERIOD_MIN = CNT_W'(2 * PULSE_CYC);

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] clamp_period(input logic [CNT_W-1:0] v);
    return (v < PERIOD_MIN) ? PERIOD_MIN : v;
  endfunction

  // Each entry holds {dir, step count}
  logic [CNT_W:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   level;
  logic             ctrl_en, ctrl_inv, overflow;
  logic [CNT_W-1:0] period, cnt, remaining;
  state_t           state;

  logic             wr_ctrl, wr_period, wr_cmd, wr_status, abort;
  logic             fifo_empty, fifo_full, low_done, pop, push, drop, busy, new_dir;
  logic [CNT_W:0]   head;
  logic [CNT_W-1:0] head_cnt;
  logic [31:0]      status_word;
  logic             unused_wdata;

  assign avs_waitrequest = 1'b0;
  assign unused_wdata    = ^avs_writedata;

  always_comb begin
    wr_ctrl     = avs_write && (avs_address == 2'd0);
    wr_period   = avs_write && (avs_address == 2'd1);
    wr_cmd      = avs_write && (avs_address == 2'd2);
    wr_status   = avs_write && (avs_address == 2'd3);
    abort       = wr_ctrl && avs_writedata[1];
    fifo_empty  = (level == '0);
    fifo_full   = (level == LVL_FULL);
    head        = fifo_mem[rd_ptr];
    head_cnt    = head[CNT_W-1:0];
    new_dir     = head[CNT_W] ^ ctrl_inv;
    busy        = (state != IDLE);
    low_done    = (state == LOW) && (cnt == '0) && (remaining == '0);
    pop         = !abort && ctrl_en && !fifo_empty && ((state == IDLE) || low_done);
    push        = wr_cmd && !abort && (!fifo_full || pop);
    drop        = wr_cmd && !abort && fifo_full && !pop;
    status_word = {16'(remaining), 8'(level), 4'b0, overflow, fifo_empty, fifo_full, busy};
  end

  always_ff @(posedge clk_clk) begin
    if (push) fifo_mem[wr_ptr] <= {avs_writedata[31], avs_writedata[CNT_W-1:0]};
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (abort) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      level <= level + (PTR_W+1)'(1);
      else if (pop && !push) level <= level - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      ctrl_en  <= 1'b0;
      ctrl_inv <= 1'b0;
      period   <= PERIOD_MIN;
      overflow <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en  <= avs_writedata[0];
        ctrl_inv <= avs_writedata[2];
      end
      if (wr_period) period <= clamp_period(avs_writedata[CNT_W-1:0]);
      if (drop)                            overflow <= 1'b1;
      else if (wr_status && avs_writedata[3]) overflow <= 1'b0;
    end
  end

  // A new step pulse always starts by counting PULSE_CYC high cycles
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state     <= IDLE;
      step      <= 1'b0;
      dir       <= 1'b0;
      cnt       <= '0;
      remaining <= '0;
    end else if (abort) begin
      state     <= IDLE;
      step      <= 1'b0;
      cnt       <= '0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop && (head_cnt != '0)) begin
            dir       <= new_dir;
            remaining <= head_cnt;
            cnt       <= CNT_W'(DIR_SETUP - 1);
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            step      <= 1'b1;
            remaining <= sat_dec(remaining);
            cnt       <= CNT_W'(PULSE_CYC - 1);
            state     <= HIGH;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        HIGH: begin
          if (cnt == '0) begin
            step  <= 1'b0;
            cnt   <= period - CNT_W'(PULSE_CYC + 1);
            state <= LOW;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        LOW: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (remaining != '0) begin
            step      <= 1'b1;
            remaining <= sat_dec(remaining);
            cnt       <= CNT_W'(PULSE_CYC - 1);
            state     <= HIGH;
          end else if (pop) begin
            if (head_cnt == '0) begin
              state <= IDLE;
            end else if (new_dir != dir) begin
              dir       <= new_dir;
              remaining <= head_cnt;
              cnt       <= CNT_W'(DIR_SETUP - 1);
              state     <= SETUP;
            end else begin
              step      <= 1'b1;
              remaining <= sat_dec(head_cnt);
              cnt       <= CNT_W'(PULSE_CYC - 1);
              state     <= HIGH;
            end
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data reflects register state before any same-cycle write
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      case (avs_address)
        2'd0:    avs_readdata <= {29'b0, ctrl_inv, 1'b0, ctrl_en};
        2'd1:    avs_readdata <= 32'(period);
        2'd3:    avs_readdata <= status_word;
        default: avs_readdata <= '0;
      endcase
    end else begin
      avs_readdata <= '0;
    end
  end

`ifdef STEP_GEN_IRQ_EN
  logic done_evt;
  assign done_evt = !abort && low_done && fifo_empty;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      irq <= 1'b0;
    end else if (drop || done_evt) begin
      irq <= 1'b1;
    end else if (wr_status && avs_writedata[4]) begin
      irq <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_avmm_step_gen.sv
// Testbench for avmm_step_gen: directed scenarios plus random bus traffic against a timeline model.
module tb_avmm_step_gen;
  localparam int CNT_W      = 16;
  localparam int PULSE_CYC  = 50;
  localparam int DIR_SETUP  = 25;
  localparam int FIFO_DEPTH = 4;
  localparam int EV_RISE = 0, EV_FALL = 1, EV_DECIDE = 2;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic [1:0]  avs_address = '0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic        avs_read = 1'b0;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic        step;
  logic        dir;
`ifdef STEP_GEN_IRQ_EN
  logic        irq;
`endif

  always #5 clk_clk = ~clk_clk;

  avmm_step_gen #(.CNT_W(CNT_W), .PULSE_CYC(PULSE_CYC), .DIR_SETUP(DIR_SETUP),
                  .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .avs_address(avs_address),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_read(avs_read),
    .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest), .step(step),
`ifdef STEP_GEN_IRQ_EN
    .dir(dir), .irq(irq)
`else
    .dir(dir)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: command queue plus absolute-time pulse events
  typedef struct { bit d; int n; } cmd_t;
  cmd_t q[$];
  bit m_en, m_inv, m_ovf, m_busy, m_step, m_dir;
  int m_period, m_rem, evt_t, evt_kind;
  bit exp_rd_vld;
  logic [31:0] exp_rd;
`ifdef STEP_GEN_IRQ_EN
  bit m_irq;
`endif

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {29'b0, m_inv, 1'b0, m_en};
      2'd1:    return 32'(m_period);
      2'd3:    return {16'(m_rem), 8'(q.size()), 4'b0, m_ovf, q.size() == 0,
                       q.size() == FIFO_DEPTH, m_busy};
      default: return 32'h0;
    endcase
  endfunction

  task automatic start_pulse();
    m_step = 1'b1;
    if (m_rem > 0) m_rem--;
    evt_kind = EV_FALL;
    evt_t = cyc + PULSE_CYC;
  endtask

  always @(posedge clk_clk) begin : model_p
    bit abort_w, set_irq;
    cmd_t h;
    cyc++;
    set_irq = 1'b0;
    if (!reset_reset_n) begin
      q.delete();
      m_en = 0; m_inv = 0; m_ovf = 0; m_busy = 0; m_step = 0; m_dir = 0;
      m_period = 2 * PULSE_CYC; m_rem = 0; evt_t = 0; evt_kind = EV_RISE;
      exp_rd_vld = 0; exp_rd = '0;
`ifdef STEP_GEN_IRQ_EN
      m_irq = 0;
`endif
    end else begin
      exp_rd_vld = avs_read;
      if (avs_read) exp_rd = model_read(avs_address);
      abort_w = avs_write && avs_address == 2'd0 && avs_writedata[1];
      if (abort_w) begin
        q.delete();
        m_busy = 0; m_step = 0; m_rem = 0;
      end else if (!m_busy) begin
        if (m_en && q.size() > 0) begin
          h = q.pop_front();
          if (h.n != 0) begin
            m_dir = h.d ^ m_inv; m_rem = h.n; m_busy = 1;
            evt_kind = EV_RISE; evt_t = cyc + DIR_SETUP;
          end
        end
      end else if (cyc == evt_t) begin
        if (evt_kind == EV_RISE) begin
          start_pulse();
        end else if (evt_kind == EV_FALL) begin
          m_step = 0; evt_kind = EV_DECIDE; evt_t = cyc + m_period - PULSE_CYC;
        end else if (m_rem > 0) begin
          start_pulse();
        end else if (m_en && q.size() > 0) begin
          h = q.pop_front();
          if (h.n == 0) m_busy = 0;
          else begin
            m_rem = h.n;
            if ((h.d ^ m_inv) != m_dir) begin
              m_dir = h.d ^ m_inv; evt_kind = EV_RISE; evt_t = cyc + DIR_SETUP;
            end else start_pulse();
          end
        end else begin
          m_busy = 0;
          if (q.size() == 0) set_irq = 1'b1;
        end
      end
      if (avs_write) begin
        case (avs_address)
          2'd0: begin m_en = avs_writedata[0]; m_inv = avs_writedata[2]; end
          2'd1: m_period = (avs_writedata[15:0] < 16'(2 * PULSE_CYC)) ? 2 * PULSE_CYC
                                                                    : int'(avs_writedata[15:0]);
          2'd2: begin
            if (q.size() < FIFO_DEPTH) q.push_back('{avs_writedata[31], int'(avs_writedata[15:0])});
            else begin m_ovf = 1; set_irq = 1'b1; end
          end
          default: begin
            if (avs_writedata[3]) m_ovf = 0;
`ifdef STEP_GEN_IRQ_EN
            if (avs_writedata[4]) m_irq = 0;
`endif
          end
        endcase
      end
`ifdef STEP_GEN_IRQ_EN
      if (set_irq) m_irq = 1;
`endif
    end
  end

  int rises[$];
  int falls[$];
  logic prev_step = 1'b0;

  always @(posedge clk_clk) begin
    #1;
    if (reset_reset_n) begin
      chk("step", 32'(step), 32'(m_step));
      chk("dir", 32'(dir), 32'(m_dir));
      chk("waitrequest", 32'(avs_waitrequest), 32'h0);
      if (exp_rd_vld) chk("readdata", avs_readdata, exp_rd);
`ifdef STEP_GEN_IRQ_EN
      chk("irq", 32'(irq), 32'(m_irq));
`endif
      if (step && !prev_step) rises.push_back(cyc);
      if (!step && prev_step) falls.push_back(cyc);
      prev_step = step;
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk_clk);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge clk_clk);
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk_clk);
    avs_address = a; avs_read = 1'b1;
    @(negedge clk_clk);
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic bus_rw(input logic [1:0] a, input logic [31:0] wd, output logic [31:0] rd);
    @(negedge clk_clk);
    avs_address = a; avs_writedata = wd; avs_write = 1'b1; avs_read = 1'b1;
    @(negedge clk_clk);
    avs_write = 1'b0; avs_read = 1'b0;
    rd = avs_readdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_clk);
  endtask

  function automatic logic [31:0] rand_data(input logic [1:0] a);
    case (a)
      2'd0:    return {29'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0),
                       1'($urandom_range(0, 9) < 8)};
      2'd1:    return 32'($urandom_range(0, 260));
      2'd2:    return {1'($urandom_range(0, 1)), 15'b0, 16'($urandom_range(0, 3))};
      default: return {27'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'b0};
    endcase
  endfunction

  initial begin
    logic [31:0] rd;
    logic [1:0]  a;
    int e;

    // Reset values while reset is held
    idle(3);
    chk("rst_step", 32'(step), 32'h0);
    chk("rst_dir", 32'(dir), 32'h0);
    chk("rst_readdata", avs_readdata, 32'h0);
    reset_reset_n = 1'b1;
    idle(2);

    bus_read(2'd0, rd); chk("rst_ctrl", rd, 32'h0);
    bus_read(2'd1, rd); chk("rst_period", rd, 32'd100);
    bus_read(2'd2, rd); chk("rst_cmd", rd, 32'h0);
    bus_read(2'd3, rd); chk("rst_status", rd, 32'h0000_0004);

    // Three steps, dir=1, 200-cycle period
    bus_write(2'd1, 32'd200);
    bus_write(2'd2, 32'h8000_0003);
    rises.delete(); falls.delete();
    bus_write(2'd0, 32'h1);
    e = cyc;
    idle(28);
    bus_read(2'd3, rd); chk("move_rem2", rd, 32'h0002_0005);
    idle(198);
    bus_read(2'd3, rd); chk("move_rem1", rd, 32'h0001_0005);
    idle(198);
    bus_read(2'd3, rd); chk("move_rem0", rd, 32'h0000_0005);
    idle(300);
    bus_read(2'd3, rd); chk("move_done_status", rd, 32'h0000_0004);
    chk("move_dir", 32'(dir), 32'h1);
    chk("move_rise_cnt", 32'(rises.size()), 32'd3);
    if (rises.size() == 3 && falls.size() == 3) begin
      chk("move_setup", 32'(rises[0] - e), 32'd26);
      chk("move_space1", 32'(rises[1] - rises[0]), 32'd200);
      chk("move_space2", 32'(rises[2] - rises[1]), 32'd200);
      for (int i = 0; i < 3; i++) chk("move_width", 32'(falls[i] - rises[i]), 32'd50);
    end

    // Overflow with enable off
    bus_write(2'd0, 32'h2);
    for (int i = 0; i < 5; i++) bus_write(2'd2, 32'h0000_0001);
    bus_read(2'd3, rd); chk("ovf_status", rd, 32'h0000_040A);
    bus_write(2'd3, 32'h8);
    bus_read(2'd3, rd); chk("ovf_cleared", rd, 32'h0000_0402);
    bus_write(2'd0, 32'h2);

    // Direction change inserts a setup gap; period clamps to the minimum
    bus_write(2'd1, 32'd50);
    bus_read(2'd1, rd); chk("period_clamp", rd, 32'd100);
    bus_write(2'd2, 32'h0000_0002);
    bus_write(2'd2, 32'h8000_0002);
    rises.delete();
    bus_write(2'd0, 32'h1);
    idle(700);
    chk("dirchg_rise_cnt", 32'(rises.size()), 32'd4);
    if (rises.size() == 4) begin
      chk("dirchg_gap0", 32'(rises[1] - rises[0]), 32'd100);
      chk("dirchg_gap1", 32'(rises[2] - rises[1]), 32'd125);
      chk("dirchg_gap2", 32'(rises[3] - rises[2]), 32'd100);
    end

    // Zero-count command in between is skipped
    bus_write(2'd0, 32'h0);
    bus_write(2'd2, 32'h8000_0002);
    bus_write(2'd2, 32'h0000_0000);
    bus_write(2'd2, 32'h8000_0002);
    rises.delete();
    bus_write(2'd0, 32'h1);
    idle(700);
    chk("zero_rise_cnt", 32'(rises.size()), 32'd4);
    if (rises.size() == 4) begin
      chk("zero_gap0", 32'(rises[1] - rises[0]), 32'd100);
      chk("zero_gap1", 32'(rises[2] - rises[1]), 32'd126);
      chk("zero_gap2", 32'(rises[3] - rises[2]), 32'd100);
    end

    // Abort in the middle of a high phase with commands queued
    bus_write(2'd0, 32'h0);
    for (int i = 0; i < 3; i++) bus_write(2'd2, 32'h0000_0003);
    bus_write(2'd0, 32'h1);
    for (int i = 0; i < 100 && !step; i++) @(negedge clk_clk);
    chk("abort_pulse_seen", 32'(step), 32'h1);
    bus_write(2'd0, 32'h3);
    chk("abort_step_low", 32'(step), 32'h0);
    bus_read(2'd3, rd); chk("abort_status", rd, 32'h0000_0004);
    rises.delete();
    idle(300);
    chk("abort_no_pulse", 32'(rises.size()), 32'd0);

    // Read and write of the same register in one cycle
    bus_rw(2'd1, 32'd150, rd); chk("rw_old_value", rd, 32'd100);
    bus_read(2'd1, rd); chk("rw_new_value", rd, 32'd150);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      a = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) a = 2'd2;
      case ($urandom_range(0, 2))
        0:       bus_write(a, rand_data(a));
        1:       bus_read(a, rd);
        default: bus_rw(a, rand_data(a), rd);
      endcase
      idle($urandom_range(0, 30));
    end

    // Drain the queue with enable on, bounded
    bus_write(2'd0, 32'h1);
    for (int i = 0; i < 20000 && (m_busy || q.size() != 0); i++) @(negedge clk_clk);
    idle(2);
    bus_read(2'd3, rd); chk("drain_status", rd & 32'h7, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
